// File: rtl/interrupt_unit.sv
// Interrupt entry / RTI return sequencer for the execute stage: pushes or pops
// PC and ALU flags through a single-port memory and stalls the pipeline meanwhile.
module interrupt_unit #(
  parameter logic [15:0] INT_VEC_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_req,
  input  logic        rti,
  input  logic [15:0] pc_in,
  input  logic [2:0]  flag_register,
  input  logic [15:0] sp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        sp_we,
  output logic [15:0] sp_next,
  output logic        flag_regsel,
  output logic [2:0]  conditions_from_memory_pop
);

  typedef enum logic [2:0] {
    IDLE, PUSH_PC, PUSH_FLAGS, LOAD_VEC, POP_FLAGS, POP_PC, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        int_pend_q;
  logic        rti_mode_q;
  logic [15:0] sp_q, pc_q;
  logic [2:0]  flg_q;
  logic        flag_regsel_q;
  logic [2:0]  cond_q;
  logic        int_start;
  logic        done;

  assign int_start = (state_q == IDLE) && !rti && (int_pend_q || int_req);
  assign done      = (state_q == DONE);

  // NOTE: every output and next-state value gets a default before the case so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    unique case (state_q)
      IDLE: begin
        if (rti)                         state_d = POP_FLAGS;
        else if (int_pend_q || int_req)  state_d = PUSH_PC;
      end
      PUSH_PC: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = pc_q;
        if (mem_ready) state_d = PUSH_FLAGS;
      end
      PUSH_FLAGS: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q - 16'd1;
        mem_wdata = {13'b0, flg_q};
        if (mem_ready) state_d = LOAD_VEC;
      end
      LOAD_VEC: begin
        mem_req  = 1'b1;
        mem_addr = INT_VEC_ADDR;
        if (mem_ready) state_d = DONE;
      end
      POP_FLAGS: begin
        mem_req  = 1'b1;
        mem_addr = sp_q + 16'd1;
        if (mem_ready) state_d = POP_PC;
      end
      POP_PC: begin
        mem_req  = 1'b1;
        mem_addr = sp_q + 16'd2;
        if (mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall       = (state_q != IDLE);
  assign pc_load     = done;
  assign pc_new      = done ? pc_q : 16'h0000;
  assign sp_we       = done;
  assign sp_next     = !done     ? 16'h0000 :
                       rti_mode_q ? sp_q + 16'd2 : sp_q - 16'd2;
  assign flag_regsel = flag_regsel_q;
  assign conditions_from_memory_pop = cond_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      int_pend_q    <= 1'b0;
      rti_mode_q    <= 1'b0;
      sp_q          <= 16'h0000;
      pc_q          <= 16'h0000;
      flg_q         <= 3'b000;
      flag_regsel_q <= 1'b0;
      cond_q        <= 3'b000;
    end else begin
      state_q       <= state_d;
      flag_regsel_q <= 1'b0;
      cond_q        <= 3'b000;

      if (int_start)    int_pend_q <= 1'b0;
      else if (int_req) int_pend_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (rti) begin
            sp_q       <= sp_in;
            rti_mode_q <= 1'b1;
          end else if (int_pend_q || int_req) begin
            sp_q       <= sp_in;
            pc_q       <= pc_in;
            flg_q      <= flag_register;
            rti_mode_q <= 1'b0;
          end
        end
        LOAD_VEC:  if (mem_ready) pc_q  <= mem_rdata;
        POP_FLAGS: if (mem_ready) flg_q <= mem_rdata[2:0];
        POP_PC: begin
          // Flag-restore outputs are registered into DONE so they are stable
          // for the ALU's negedge update.
          if (mem_ready) begin
            pc_q          <= mem_rdata;
            flag_regsel_q <= 1'b1;
            cond_q        <= flg_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/interrupt_unit.md
# interrupt_unit

Sequencer for interrupt entry and RTI return in the execute stage. On an interrupt it pushes the return PC and the ALU flag register to the stack and fetches the handler vector. On RTI it pops the flags and PC back. It drives the ALU's `flag_regsel` / `conditions_from_memory_pop` restore path and stalls the pipeline while a sequence runs.

## Interface
- `INT_VEC_ADDR`, default 16'h0000: memory word holding the interrupt handler address.
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: synchronous reset, active-low.
- `int_req` in 1: interrupt request pulse; latched.
- `rti` in 1: one-cycle pulse; an RTI is in execute.
- `pc_in` in 16: return PC to push; sampled at sequence start.
- `flag_register` in 3: ALU flags {C,N,Z}; sampled at sequence start.
- `sp_in` in 16: current SP; sampled at sequence start.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: word address.
- `mem_wdata` out 16: write data.
- `mem_rdata` in 16: read data; valid while `mem_ready` = 1.
- `mem_ready` in 1: access completes at the posedge where `mem_req` & `mem_ready`.
- `stall` out 1: freeze the pipeline; high in every state except IDLE.
- `pc_load` out 1: one-cycle pulse; load `pc_new` into the PC.
- `pc_new` out 16: new PC value.
- `sp_we` out 1: one-cycle pulse; write `sp_next` into SP.
- `sp_next` out 16: new SP value.
- `flag_regsel` out 1: 1 = ALU loads its flags from `conditions_from_memory_pop`.
- `conditions_from_memory_pop` out 3: popped flags.

## Operation
- States: IDLE, PUSH_PC, PUSH_FLAGS, LOAD_VEC, POP_FLAGS, POP_PC, DONE.
- `int_pend` register:
  - Set by `int_req` in any state.
  - Cleared when an interrupt sequence starts.
- At a posedge in IDLE:
  - If `rti` = 1: latch `sp_q` = `sp_in`, go to POP_FLAGS. RTI has priority over a pending interrupt.
  - Else if `int_pend` or `int_req`: latch `sp_q` = `sp_in`, `pc_q` = `pc_in`, `flg_q` = `flag_register`, go to PUSH_PC.
- Interrupt path:
  - PUSH_PC: write `pc_q` to `sp_q`.
  - PUSH_FLAGS: write {13'b0, `flg_q`} to `sp_q`-1.
  - LOAD_VEC: read `INT_VEC_ADDR` into `pc_q`.
  - DONE: `pc_load` = 1, `pc_new` = vector, `sp_we` = 1, `sp_next` = `sp_q`-2, `flag_regsel` = 0.
- RTI path:
  - POP_FLAGS: read `sp_q`+1; capture `mem_rdata[2:0]` into `flg_q`.
  - POP_PC: read `sp_q`+2 into `pc_q`.
  - DONE: `pc_load` = 1, `pc_new` = `pc_q`, `sp_we` = 1, `sp_next` = `sp_q`+2, `flag_regsel` = 1, `conditions_from_memory_pop` = `flg_q`.
- DONE always returns to IDLE.
- A pending interrupt is serviced from IDLE on the following cycle; it pushes the PC just restored.
- SP arithmetic is 16-bit modulo 2^16 (0x0000-1 = 0xFFFF; 0xFFFF+2 = 0x0001).
- `rti` outside IDLE is ignored; the pipeline is stalled, so none is issued.
- Outside DONE: `flag_regsel`, `pc_load`, `sp_we` are 0.

## Timing
- Reset: state IDLE, `int_pend` = 0, all outputs 0.
- Reset mid-sequence aborts the sequence with no `pc_load` or `sp_we`. Memory writes already completed stay.
- Memory handshake:
  - In a memory state, `mem_req` = 1 with `mem_we`, `mem_addr`, `mem_wdata` stable until the completing edge.
  - The state advances only on `mem_ready`.
  - `mem_ready` is accepted in the same cycle `mem_req` rises (zero-wait).
- Zero-wait latency:
  - Interrupt: IDLE edge, then PUSH_PC, PUSH_FLAGS, LOAD_VEC, DONE. `pc_load` in the 4th cycle after the sampling edge; `stall` is high 4 cycles.
  - RTI: 3 cycles (POP_FLAGS, POP_PC, DONE).
- Each wait cycle adds 1 cycle.
- `flag_regsel` and `conditions_from_memory_pop` are driven from registers and held for the whole DONE cycle, so the ALU's negedge flag update captures them.
- `stall` is combinational from the state.

## Test plan
- Interrupt, zero-wait: `sp_in` = 0x0100, `pc_in` = 0x0042, flags = 3'b101, mem[0] = 0x0200.
  - Writes: 0x0042 to 0x0100, 0x0005 to 0x00FF.
  - DONE: `pc_new` = 0x0200, `sp_next` = 0x00FE; `stall` high 4 cycles.
- RTI after the above: `sp_in` = 0x00FE.
  - Reads 0x00FF then 0x0100.
  - DONE: `pc_new` = 0x0042, `flag_regsel` = 1, `conditions_from_memory_pop` = 3'b101, `sp_next` = 0x0100.
- Wait states: `mem_ready` low 2 cycles on each access. `mem_addr` / `mem_wdata` stay stable; the interrupt takes 10 cycles.
- Simultaneous `rti` and `int_req` in IDLE:
  - RTI runs first.
  - The next cycle starts the interrupt, pushing the restored PC to the restored SP.
- Wrap: `sp_in` = 0x0000 interrupt writes 0x0000 then 0xFFFF, `sp_next` = 0xFFFE. RTI from 0xFFFF reads 0x0000, 0x0001, `sp_next` = 0x0001.
- `rst_n` low during PUSH_FLAGS (`mem_ready` held low): next cycle IDLE, all outputs 0, no `pc_load`/`sp_we`, `int_pend` cleared.
